// File: rtl/led_matrix_scan_ctrl.sv
// Column-multiplexed scan controller for a 4x8 LED matrix with a double-buffered
// frame, anti-ghosting blanking and 3-bit brightness PWM.
module led_matrix_scan_ctrl #(
  parameter int unsigned SLOT_CYCLES  = 3000,
  parameter int unsigned BLANK_CYCLES = 24
) (
  input  logic       clk12MHz,
  input  logic       rst_n,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [1:0] wr_col,
  input  logic [7:0] wr_data,
  input  logic       swap_req,
  output logic       swap_pending,
  input  logic [2:0] bright,
  output logic       frame_start,
  output logic [3:0] column_leds,
  output logic [7:0] line_leds
);

  localparam int unsigned DRIVE_CYCLES = SLOT_CYCLES - BLANK_CYCLES;
  localparam int unsigned CW           = $clog2(SLOT_CYCLES) + 1;
  localparam int unsigned PW           = CW + 3;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [CW-1:0]   on_cycles, on_cycles_nx;
  logic [1:0]      col, col_nx;
  logic [7:0]      pattern, pattern_nx;
  logic [3:0][7:0] front, back;
  logic [PW-1:0]   on_product;
  logic            boundary;
  logic            wr_accept;
  logic            swap_pending_nx;
  logic [3:0]      column_nx;
  logic [7:0]      line_nx;

  assign on_product = (PW'(bright) + PW'(1)) * PW'(DRIVE_CYCLES);
  assign wr_accept  = wr_valid && wr_ready;

  // Next-state and next-output logic; outputs are registered from these values
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt + CW'(1);
    col_nx       = col;
    pattern_nx   = pattern;
    on_cycles_nx = on_cycles;
    boundary     = 1'b0;
    case (state)
      BLANK: begin
        if (cnt == CW'(BLANK_CYCLES - 1)) begin
          state_nx     = DRIVE;
          cnt_nx       = '0;
          pattern_nx   = front[col];
          on_cycles_nx = CW'(on_product >> 3);
        end
      end
      DRIVE: begin
        if (cnt == CW'(DRIVE_CYCLES - 1)) begin
          state_nx = BLANK;
          cnt_nx   = '0;
          col_nx   = col + 2'd1;
          boundary = (col == 2'd3);
        end
      end
      default: begin
        state_nx = BLANK;
        cnt_nx   = '0;
      end
    endcase

    swap_pending_nx = swap_pending ? !boundary : swap_req;

    column_nx = (state_nx == DRIVE) ? ~(4'b0001 << col_nx) : 4'b1111;
    line_nx   = ((state_nx == DRIVE) && (cnt_nx < on_cycles_nx)) ? pattern_nx : 8'h00;
  end

  always_ff @(posedge clk12MHz or negedge rst_n) begin
    if (!rst_n) begin
      state        <= BLANK;
      cnt          <= '0;
      col          <= 2'd0;
      pattern      <= 8'h00;
      on_cycles    <= '0;
      swap_pending <= 1'b0;
      wr_ready     <= 1'b1;
      frame_start  <= 1'b0;
      column_leds  <= 4'b1111;
      line_leds    <= 8'h00;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      col          <= col_nx;
      pattern      <= pattern_nx;
      on_cycles    <= on_cycles_nx;
      swap_pending <= swap_pending_nx;
      wr_ready     <= !swap_pending_nx;
      frame_start  <= boundary;
      column_leds  <= column_nx;
      line_leds    <= line_nx;
    end
  end

  // Back buffer is written only while no swap is pending, so the copy sees a stable image
  always_ff @(posedge clk12MHz or negedge rst_n) begin
    if (!rst_n) begin
      front <= '0;
      back  <= '0;
    end else begin
      if (wr_accept) begin
        back[wr_col] <= wr_data;
      end
      if (boundary && swap_pending) begin
        front <= back;
      end
    end
  end

endmodule

// File: tb/tb_led_matrix_scan_ctrl.sv
// Scoreboard bench for led_matrix_scan_ctrl: per-slot expectations are queued from a
// transaction-level model of the frame buffers and compared against observed slots.
module tb_led_matrix_scan_ctrl;

  localparam int SLOT  = 40;
  localparam int BLANK = 8;
  localparam int DRIVE = SLOT - BLANK;

  logic       clk12MHz = 1'b0;
  logic       rst_n;
  logic       wr_valid;
  logic       wr_ready;
  logic [1:0] wr_col;
  logic [7:0] wr_data;
  logic       swap_req;
  logic       swap_pending;
  logic [2:0] bright;
  logic       frame_start;
  logic [3:0] column_leds;
  logic [7:0] line_leds;

  led_matrix_scan_ctrl #(.SLOT_CYCLES(SLOT), .BLANK_CYCLES(BLANK)) dut (
    .clk12MHz    (clk12MHz),
    .rst_n       (rst_n),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_col      (wr_col),
    .wr_data     (wr_data),
    .swap_req    (swap_req),
    .swap_pending(swap_pending),
    .bright      (bright),
    .frame_start (frame_start),
    .column_leds (column_leds),
    .line_leds   (line_leds)
  );

  always #5 clk12MHz = ~clk12MHz;

  typedef struct {
    int         col_idx;
    logic [3:0] col;
    logic [7:0] pat;
    int         on;
    bit         fs;
  } slot_exp_t;

  slot_exp_t  sb[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  logic [7:0] m_front[4];
  logic [7:0] m_back[4];
  bit         m_pending;
  bit         fs_exp;
  bit         last_acc;
  int         phase;
  int         col_pos;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_front[i] = 8'h00;
      m_back[i]  = 8'h00;
    end
    m_pending = 1'b0;
    fs_exp    = 1'b0;
    last_acc  = 1'b0;
    phase     = 0;
    col_pos   = 0;
  endtask

  // Advance one clock, applying the effect of the upcoming edge to the model
  task automatic step();
    bit bnd;
    bnd      = (phase == SLOT - 1) && (col_pos == 3);
    last_acc = wr_valid && !m_pending;
    if (last_acc) m_back[wr_col] = wr_data;
    if (m_pending) begin
      if (bnd) begin
        for (int i = 0; i < 4; i++) m_front[i] = m_back[i];
        m_pending = 1'b0;
      end
    end else if (swap_req) begin
      m_pending = 1'b1;
    end
    @(negedge clk12MHz);
    fs_exp = bnd;
    phase++;
    if (phase == SLOT) begin
      phase   = 0;
      col_pos = (col_pos + 1) % 4;
    end
  endtask

  task automatic check_slot();
    slot_exp_t  e;
    logic [3:0] one;
    logic [3:0] dcol;
    logic [7:0] dpat;
    int         on_n;
    int         hs_bad;
    bit         blank_ok, col_ok, shape_ok, seen_zero, fs0, fs_other;
    one       = 4'b0001;
    e.col_idx = col_pos;
    e.col     = ~(one << col_pos);
    e.pat     = m_front[col_pos];
    e.on      = (e.pat == 8'h00) ? 0 : (((int'(bright) + 1) * DRIVE) >> 3);
    e.fs      = fs_exp;
    sb.push_back(e);
    on_n = 0; hs_bad = 0; dcol = 4'hF; dpat = 8'h00;
    blank_ok = 1; col_ok = 1; shape_ok = 1; seen_zero = 0; fs0 = 0; fs_other = 0;
    for (int i = 0; i < SLOT; i++) begin
      if ((wr_ready !== !m_pending) || (swap_pending !== m_pending)) hs_bad++;
      if (i == 0) fs0 = (frame_start === 1'b1);
      else if (frame_start !== 1'b0) fs_other = 1;
      if (i < BLANK) begin
        if (column_leds !== 4'hF || line_leds !== 8'h00) blank_ok = 0;
      end else begin
        if (i == BLANK) begin
          dcol = column_leds;
          dpat = line_leds;
        end
        if (column_leds !== dcol) col_ok = 0;
        if (line_leds !== 8'h00) begin
          on_n++;
          if (seen_zero || line_leds !== dpat) shape_ok = 0;
        end else begin
          seen_zero = 1;
        end
      end
      step();
    end
    e = sb.pop_front();
    n_checks++;
    if (!blank_ok) begin
      n_fail++;
      $display("FAIL slot_blank col%0d: blank window not all-off", e.col_idx);
    end
    n_checks++;
    if (dcol !== e.col || !col_ok) begin
      n_fail++;
      $display("FAIL slot_column col%0d: got %b (stable=%0d) expected %b", e.col_idx, dcol, col_ok, e.col);
    end
    n_checks++;
    if (on_n != e.on || !shape_ok) begin
      n_fail++;
      $display("FAIL slot_on_time col%0d: got %0d cycles (shape=%0d) expected %0d", e.col_idx, on_n, shape_ok, e.on);
    end
    if (e.on > 0) begin
      n_checks++;
      if (dpat !== e.pat) begin
        n_fail++;
        $display("FAIL slot_pattern col%0d: got %h expected %h", e.col_idx, dpat, e.pat);
      end
    end
    n_checks++;
    if (fs0 != e.fs || fs_other) begin
      n_fail++;
      $display("FAIL slot_frame_start col%0d: got %0d (extra=%0d) expected %0d", e.col_idx, fs0, fs_other, e.fs);
    end
    n_checks++;
    if (hs_bad != 0) begin
      n_fail++;
      $display("FAIL slot_handshake col%0d: %0d cycles wr_ready/swap_pending off model, expected 0", e.col_idx, hs_bad);
    end
  endtask

  task automatic run_to_col(input int c);
    while (phase != 0) step();
    while (col_pos != c) check_slot();
  endtask

  task automatic do_write(input logic [1:0] c, input logic [7:0] d, output int acc_phase, output int acc_col);
    int n;
    bit done, bad;
    n = 0; done = 0; bad = 0; acc_phase = -1; acc_col = -1;
    wr_valid = 1'b1; wr_col = c; wr_data = d;
    while (!done && n < 400) begin
      if (wr_ready !== !m_pending) bad = 1;
      acc_phase = phase;
      acc_col   = col_pos;
      step();
      n++;
      done = last_acc;
    end
    wr_valid = 1'b0;
    n_checks++;
    if (!done || bad) begin
      n_fail++;
      $display("FAIL write_handshake col%0d: accepted=%0d wr_ready_mismatch=%0d", c, done, bad);
    end
  endtask

  task automatic pulse_swap();
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_valid = 1'b0; wr_col = 2'd0; wr_data = 8'h00; swap_req = 1'b0; bright = 3'd7;
    model_reset();
    repeat (3) @(posedge clk12MHz);
    @(negedge clk12MHz);
    n_checks++;
    if (column_leds !== 4'hF || line_leds !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_leds: got col=%b line=%h expected 1111/00", column_leds, line_leds);
    end
    n_checks++;
    if (wr_ready !== 1'b1 || swap_pending !== 1'b0 || frame_start !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got rdy=%b pend=%b fs=%b expected 1/0/0", wr_ready, swap_pending, frame_start);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_scan_idle();
    for (int i = 0; i < 5; i++) check_slot();
  endtask

  task automatic test_swap();
    int ap, ac;
    do_write(2'd1, 8'hA5, ap, ac);
    do_write(2'd2, 8'h3C, ap, ac);
    pulse_swap();
    n_checks++;
    if (swap_pending !== 1'b1 || wr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL swap_pending_set: got pend=%b rdy=%b expected 1/0", swap_pending, wr_ready);
    end
    run_to_col(0);
    for (int i = 0; i < 4; i++) check_slot();
  endtask

  task automatic test_brightness();
    int ap, ac;
    logic [2:0] levels[3];
    levels[0] = 3'd0; levels[1] = 3'd3; levels[2] = 3'd7;
    do_write(2'd0, 8'hFF, ap, ac);
    pulse_swap();
    run_to_col(0);
    for (int k = 0; k < 3; k++) begin
      bright = levels[k];
      check_slot();
      run_to_col(0);
    end
    bright = 3'd7;
  endtask

  task automatic test_hold_pending();
    int ap, ac;
    pulse_swap();
    do_write(2'd3, 8'h81, ap, ac);
    n_checks++;
    if (ap != 0 || ac != 0) begin
      n_fail++;
      $display("FAIL held_write_position: accepted at col%0d phase%0d expected col0 phase0", ac, ap);
    end
    run_to_col(0);
    for (int i = 0; i < 4; i++) check_slot();
    pulse_swap();
    run_to_col(0);
    for (int i = 0; i < 4; i++) check_slot();
  endtask

  task automatic test_back_to_back_swap();
    int ap, ac;
    wr_valid = 1'b1; wr_col = 2'd0; wr_data = 8'h5A; swap_req = 1'b1;
    step();
    wr_valid = 1'b0; swap_req = 1'b0;
    n_checks++;
    if (swap_pending !== 1'b1 || wr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL first_swap_req: got pend=%b rdy=%b expected 1/0", swap_pending, wr_ready);
    end
    repeat (3) step();
    pulse_swap();
    n_checks++;
    if (swap_pending !== 1'b1) begin
      n_fail++;
      $display("FAIL second_swap_req: got pend=%b expected 1", swap_pending);
    end
    run_to_col(0);
    for (int i = 0; i < 4; i++) check_slot();
    do_write(2'd0, 8'h11, ap, ac);
    run_to_col(0);
    for (int i = 0; i < 4; i++) check_slot();
  endtask

  task automatic test_reset_mid_drive();
    run_to_col(2);
    repeat (20) step();
    n_checks++;
    if (column_leds !== 4'b1011 || line_leds !== 8'h3C) begin
      n_fail++;
      $display("FAIL pre_reset_drive: got col=%b line=%h expected 1011/3c", column_leds, line_leds);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (column_leds !== 4'hF || line_leds !== 8'h00) begin
      n_fail++;
      $display("FAIL async_reset_leds: got col=%b line=%h expected 1111/00", column_leds, line_leds);
    end
    @(posedge clk12MHz);
    @(negedge clk12MHz);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 5; i++) check_slot();
    pulse_swap();
    run_to_col(0);
    for (int i = 0; i < 4; i++) check_slot();
  endtask

  initial begin
    test_reset();
    test_scan_idle();
    test_swap();
    test_brightness();
    test_hold_pending();
    test_back_to_back_swap();
    test_reset_mid_drive();
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
